// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - builds a DUT truth table from (vec, y) pairs with coverage, then grades it against a golden table
module truth_table_checker #(
  parameter int N_IN = 4,
  localparam int ENTRIES = 2 ** N_IN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ENTRIES-1:0] expected,
  input  logic               vec_valid,
  output logic               vec_ready,
  input  logic [N_IN-1:0]    vec,
  input  logic               y,
  output logic [ENTRIES-1:0] tbl,
  output logic [ENTRIES-1:0] seen,
  output logic [N_IN:0]      count,
  output logic               done,
  output logic               pass,
  output logic               conflict,
  output logic [N_IN-1:0]    first_bad
);

  localparam int CNT_W = N_IN + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ENTRIES-1:0] tbl_q, tbl_d;
  logic [ENTRIES-1:0] seen_q, seen_d;
  logic [ENTRIES-1:0] expected_q, expected_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               conflict_q, conflict_d;
  logic [N_IN-1:0]    first_bad_q, first_bad_d;
  logic               vec_ready_q, vec_ready_d;

  logic               hs;
  logic [ENTRIES-1:0] diff;
  logic [N_IN-1:0]    diff_idx;

  assign hs   = vec_valid && vec_ready_q;
  assign diff = tbl_q ^ expected_q;

  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    diff_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (diff[i]) diff_idx = N_IN'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    tbl_d       = tbl_q;
    seen_d      = seen_q;
    expected_d  = expected_q;
    count_d     = count_q;
    done_d      = done_q;
    pass_d      = pass_q;
    conflict_d  = conflict_q;
    first_bad_d = first_bad_q;

    if (start) begin
      tbl_d       = '0;
      seen_d      = '0;
      count_d     = '0;
      conflict_d  = 1'b0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      first_bad_d = '0;
      expected_d  = expected;
      state_d     = CAPTURE;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (hs) begin
            if (!seen_q[vec]) begin
              tbl_d[vec]  = y;
              seen_d[vec] = 1'b1;
              count_d     = count_q + CNT_W'(1);
              if (count_q == CNT_W'(ENTRIES - 1)) state_d = CHECK;
            end else if (tbl_q[vec] != y) begin
              conflict_d = 1'b1;
            end
          end
        end
        CHECK: begin
          pass_d      = (diff == '0) && !conflict_q;
          first_bad_d = diff_idx;
          done_d      = 1'b1;
          state_d     = DONE;
        end
        default: ;
      endcase
    end

    vec_ready_d = (state_d == CAPTURE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tbl_q       <= '0;
      seen_q      <= '0;
      expected_q  <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      conflict_q  <= 1'b0;
      first_bad_q <= '0;
      vec_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      seen_q      <= seen_d;
      expected_q  <= expected_d;
      count_q     <= count_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      conflict_q  <= conflict_d;
      first_bad_q <= first_bad_d;
      vec_ready_q <= vec_ready_d;
    end
  end

  assign vec_ready = vec_ready_q;
  assign tbl       = tbl_q;
  assign seen      = seen_q;
  assign count     = count_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign conflict  = conflict_q;
  assign first_bad = first_bad_q;

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Hardware response-side counterpart to the exhaustive stimulus benches used for small combinational exercises.
- Consumes (input vector, observed output) pairs from a DUT harness and builds the DUT's truth table with a coverage bitmap.
- Once every input combination has been seen, compares the built table against a golden table and reports pass/fail plus the first failing index.
- Sits between a vector source and a status/LED or logging block.

Parameters:
- N_IN, 4, number of DUT input bits; table depth ENTRIES = 2**N_IN (16 by default).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: clear all state, latch expected, enter CAPTURE.
- expected  in  ENTRIES  golden truth table, bit i = expected y for input i; sampled only on start.
- vec_valid  in  1  vec/y pair valid.
- vec_ready  out  1  checker accepts a pair this cycle.
- vec  in  N_IN  input combination applied to the DUT; bit N_IN-1 is the MSB (a).
- y  in  1  DUT output for vec.
- tbl  out  ENTRIES  captured truth table.
- seen  out  ENTRIES  coverage bitmap.
- count  out  N_IN+1  number of distinct vectors captured, 0..ENTRIES.
- done  out  1  level; results valid.
- pass  out  1  level; valid when done.
- conflict  out  1  sticky; same vector observed with two different y values.
- first_bad  out  N_IN  lowest index where tbl != expected; 0 if none.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - tbl, seen, expected_q, count, first_bad all 0.
  - done, pass, conflict, vec_ready all 0.
- States: IDLE, CAPTURE, CHECK, DONE. vec_ready=1 only in CAPTURE (registered state decode, no combinational path from vec_valid).
- IDLE: waits for start; vec_valid ignored.
- start, any state: at that edge clear tbl, seen, count, conflict, done, pass, first_bad; latch expected_q<=expected; state<=CAPTURE. start has priority over a simultaneous handshake; that pair is dropped.
- Handshake = vec_valid && vec_ready, sampled at the rising edge.
  - New vector (seen[vec]=0): tbl[vec]<=y, seen[vec]<=1, count<=count+1.
  - Duplicate with equal y: no change; count not incremented.
  - Duplicate with different y: conflict<=1; tbl keeps the first value; count unchanged.
- CAPTURE exit: the handshake edge that takes count from ENTRIES-1 to ENTRIES also sets state<=CHECK. Vector order is arbitrary.
- CHECK (exactly one cycle):
  - diff = tbl ^ expected_q.
  - pass <= (diff==0) && !conflict.
  - first_bad <= priority-encoded lowest set bit of diff, 0 if diff==0.
  - done<=1; state<=DONE.
  - Latency: last handshake edge E -> results and done registered at edge E+1.
- DONE: all outputs held until start or reset; vec_valid ignored, vec_ready=0.
- count width N_IN+1 so ENTRIES is representable; it never exceeds ENTRIES and never wraps.
- Reset mid-operation: immediate return to reset values; a capture in progress is discarded.
- Incomplete coverage: the block stays in CAPTURE indefinitely (no timeout); done stays 0.

Test Plan:
- start with expected=16'h6996 (4-input XOR); drive vec 0..15 in ascending order with y=^vec, vec_valid held high -> count=16, done=1 one cycle after the 16th handshake, pass=1, tbl=16'h6996, seen=16'hFFFF, first_bad=0.
- Same as the first scenario but y inverted for vec=5 and vec=11 -> pass=0, first_bad=5, conflict=0.
- Vectors in descending order, vec=3 sent twice with equal y, then a third time with y flipped -> count stays 16 (no double count), conflict=1, pass=0, tbl[3] = first value.
- Reset asserted after 7 captured vectors -> all outputs 0 asynchronously, state IDLE; vec_valid ignored until start.
- start asserted in DONE with expected=16'h8000 (4-input AND), simultaneous with vec_valid -> that pair dropped, tbl/seen/count cleared, new capture of AND responses -> pass=1.
- Only 15 distinct vectors supplied -> done=0, count=15, vec_ready stays 1.
